// File: rtl/serial_word_receiver.sv
// serial_word_receiver
//   Hunts a serial bit stream (from the upstream shift register's MSB) for a
//   sync pattern, then assembles WORDS_PER_FRAME words of WORD_W bits each and
//   presents them on a one-deep valid/ready output register.
//
// Optional feature: define SERIAL_WORD_RECEIVER_PARITY_EN to expect one odd
//   parity bit after every data word; ParErr then flags a mismatch. With the
//   macro undefined no parity bit is consumed and ParErr is tied 0.
//
// Ports:
//   Clk        clock, rising edge
//   ResetB     synchronous active-low reset
//   BitIn      serial data bit, qualified by BitValid
//   BitValid   BitIn is sampled only when 1
//   WordReady  consumer accepts WordOut when WordValid & WordReady
//   OvrClr     synchronous clear of sticky Overrun
//   WordOut    assembled word, first received bit is MSB
//   WordValid  WordOut holds an unaccepted word
//   FrameFirst word is the first of its frame
//   Locked     1 while assembling a frame
//   Overrun    sticky, set when a completed word is dropped
//   ParErr     parity mismatch for WordOut (0 without parity feature)
//
// WORD_W and SYNC_W must be at least 2.
module serial_word_receiver #(
  parameter int                WORD_W          = 4,
  parameter int                SYNC_W          = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT        = 4'b1011,
  parameter int                WORDS_PER_FRAME = 2
) (
  input  logic              Clk,
  input  logic              ResetB,
  input  logic              BitIn,
  input  logic              BitValid,
  input  logic              WordReady,
  input  logic              OvrClr,
  output logic [WORD_W-1:0] WordOut,
  output logic              WordValid,
  output logic              FrameFirst,
  output logic              Locked,
  output logic              Overrun,
  output logic              ParErr
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam int FC_W = $clog2(SYNC_W + 1);
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
  localparam int LAST_BIT = WORD_W;      // parity bit closes the word
`else
  localparam int LAST_BIT = WORD_W - 1;
`endif

  typedef enum logic {HUNT = 1'b0, ASSEMBLE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SYNC_W-1:0] hist_q, hist_d;
  logic [FC_W-1:0]   fill_q, fill_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              first_q, first_d;
  logic              ovr_q, ovr_d;
  logic              perr_q, perr_d;

  logic [SYNC_W-1:0] hist_sh;
  logic [WORD_W-1:0] asm_sh;
  logic [FC_W-1:0]   fill_inc;
  logic              done;
  logic [WORD_W-1:0] done_word;
  logic              done_perr;
  logic              load;

  assign hist_sh  = {hist_q[SYNC_W-2:0], BitIn};
  assign asm_sh   = {asm_q[WORD_W-2:0], BitIn};
  assign fill_inc = (fill_q == FC_W'(SYNC_W)) ? fill_q : fill_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    out_d      = out_q;
    vld_d      = vld_q;
    first_d    = first_q;
    ovr_d      = ovr_q;
    perr_d     = perr_q;
    done       = 1'b0;
    done_word  = asm_sh;
    done_perr  = 1'b0;
    load       = 1'b0;

    case (state_q)
      HUNT: begin
        if (BitValid) begin
          hist_d = hist_sh;
          fill_d = fill_inc;
          // fill guard keeps reset-time zeros from forming a false match
          if (hist_sh == SYNC_PAT && fill_inc == FC_W'(SYNC_W)) begin
            state_d    = ASSEMBLE;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            asm_d      = '0;
          end
        end
      end
      ASSEMBLE: begin
        if (BitValid) begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
          // data bits shift in; the parity bit only feeds the check
          if (bit_cnt_q < BC_W'(WORD_W)) asm_d = asm_sh;
          done_word = asm_q;
          done_perr = ~(^asm_q ^ BitIn);
`else
          asm_d = asm_sh;
`endif
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BC_W'(LAST_BIT)) begin
            done       = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == 8'(WORDS_PER_FRAME - 1)) begin
              state_d = HUNT;
              hist_d  = '0;
              fill_d  = '0;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    // Output slot is free if empty or being drained this same cycle.
    load = done & (~vld_q | WordReady);
    if (load) begin
      out_d   = done_word;
      vld_d   = 1'b1;
      first_d = (word_cnt_q == 8'd0);
      perr_d  = done_perr;
    end else if (vld_q & WordReady) begin
      vld_d = 1'b0;
    end

    // Set beats clear when both happen in one cycle.
    if (done & ~load)  ovr_d = 1'b1;
    else if (OvrClr)   ovr_d = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (!ResetB) begin
      state_q    <= HUNT;
      hist_q     <= '0;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      asm_q      <= '0;
      out_q      <= '0;
      vld_q      <= 1'b0;
      first_q    <= 1'b0;
      ovr_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      out_q      <= out_d;
      vld_q      <= vld_d;
      first_q    <= first_d;
      ovr_q      <= ovr_d;
      perr_q     <= perr_d;
    end
  end

  assign WordOut    = out_q;
  assign WordValid  = vld_q;
  assign FrameFirst = first_q;
  assign Locked     = (state_q == ASSEMBLE);
  assign Overrun    = ovr_q;
  assign ParErr     = perr_q;

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Downstream consumer of the 4-bit parallel-load shift register's serial output (the register's MSB, Q[3]).
- Hunts the serial bit stream for a sync pattern, then assembles a fixed number of data words per frame.
- Presents each assembled word on a one-deep valid/ready output register.
- Sits between the serializer stage and the word-level datapath.

Parameters:
- WORD_W, 4: data bits per word.
- SYNC_W, 4: sync pattern length in bits.
- SYNC_PAT, 4'b1011: sync pattern; SYNC_W bits, first-received bit is MSB.
- WORDS_PER_FRAME, 2: data words assembled after each sync match; range 1..255.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- ResetB  input  1  reset; synchronous, active-low.
- BitIn  input  1  serial data bit, driven from the shift register's Q[3].
- BitValid  input  1  BitIn is sampled only on cycles where this is 1.
- WordReady  input  1  consumer accepts WordOut when WordValid=1 and WordReady=1.
- OvrClr  input  1  clears Overrun; synchronous.
- WordOut  output  WORD_W  assembled word; first-received bit is MSB.
- WordValid  output  1  WordOut holds an unaccepted word.
- FrameFirst  output  1  qualifies WordOut; 1 when the word is the first of its frame.
- Locked  output  1  1 while in ASSEMBLE.
- Overrun  output  1  sticky; set when a completed word is dropped.
- ParErr  output  1  qualifies WordOut; see Optional Feature.

Behaviour:
- Reset (ResetB=0 at a clock edge):
  - State goes to HUNT.
  - History, fill count, bit count, word count and assembly register are cleared.
  - WordOut=0, WordValid=0, FrameFirst=0, Locked=0, Overrun=0, ParErr=0.
  - Reset overrides every other input, including mid-frame; any partial word is discarded.
- State HUNT:
  - On each BitValid: hist <= {hist[SYNC_W-2:0], BitIn}; fill count increments, saturating at SYNC_W.
  - Match condition: BitValid=1, shifted value equals SYNC_PAT, and fill count (including this bit) >= SYNC_W. Pre-fill zeros never match.
  - On match: go to ASSEMBLE; bit count=0, word count=0. Locked=1 from the next cycle.
  - Matching is sliding; overlapping candidates are detected.
- State ASSEMBLE:
  - Each BitValid shifts BitIn into the assembly register LSB side, so the first bit ends up as MSB.
  - BitValid=0 cycles are ignored; there is no timeout.
  - A word completes on the BitValid where bit count = WORD_W-1.
  - Completed word goes to the output register if the register is empty, or is being accepted in that same cycle (WordValid=1 and WordReady=1).
  - Otherwise the word is dropped and Overrun is set.
  - FrameFirst for the loaded word = (word count == 0).
  - After the word with index WORDS_PER_FRAME-1 completes, return to HUNT with history and fill count cleared. Locked=0 from the next cycle.
  - Sync bits are never interpreted as data; the sync pattern is not searched for during ASSEMBLE.
- Output register:
  - Latency: WordValid rises the cycle after the last bit of a word is sampled.
  - WordOut and FrameFirst are stable while WordValid=1 and WordReady=0.
  - Acceptance with no simultaneous load: WordValid=0 the next cycle; WordOut holds its last value.
- Overrun:
  - Sticky; cleared by OvrClr=1 or reset.
  - If a set event and OvrClr=1 occur in the same cycle, set wins.
- Widths: bit count is clog2(WORD_W+1) bits, word count is 8 bits; neither wraps within a frame.

Optional Feature:
- Macro: SERIAL_WORD_RECEIVER_PARITY_EN.
- Defined:
  - Each data word is followed by one odd-parity bit: the WORD_W data bits plus the parity bit contain an odd number of 1s.
  - Word completion moves to the parity bit's BitValid, so latency is measured from the parity bit.
  - ParErr is loaded with the word (1 = parity mismatch) and held with WordOut.
  - The word is still delivered when ParErr=1.
- Not defined:
  - No parity bit is expected.
  - ParErr is tied 0.

Test Plan:
All scenarios use default parameters with WORDS_PER_FRAME=2, BitValid=1 every cycle unless stated.
- Reset: ResetB=0 for 3 cycles while streaming 1011 0110 -> all outputs 0 throughout; Locked=0 after release until a fresh 1011 is seen.
- Basic frame, WordReady=1: bits 1011 0110 1001 -> Locked=1 the cycle after the 4th bit.
  - WordOut=4'h6, FrameFirst=1 for one cycle after bit 8.
  - WordOut=4'h9, FrameFirst=0 after bit 12.
  - Locked=0 the cycle after bit 12.
- Sliding sync plus gaps: bits 1 1 0 1 1 with BitValid low for 2 cycles between each bit -> match on the 5th bit; following 0011 1100 yields 4'h3 then 4'hC.
- Backpressure: WordReady=0 for the whole basic frame -> WordOut=4'h6 held, FrameFirst=1, WordValid=1; 4'h9 dropped; Overrun=1.
  - Then OvrClr=1 for one cycle -> Overrun=0.
  - Then WordReady=1 -> 4'h6 accepted.
- Simultaneous accept/load: hold WordReady=0 until the cycle the second word completes, then WordReady=1 that cycle -> 4'h6 accepted, 4'h9 loaded next cycle, Overrun=0.
- Parity (macro defined): bits 1011, 0110+1, 1001+0 -> 4'h6 with ParErr=0, then 4'h9 with ParErr=1.
